// File: rtl/bloom_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bloom_filter_pkg
// Brief    : Shared types and constants for the bloom-filter LUT controller.
// Revision : 1.0
// ============================================================================
package bloom_filter_pkg;

  localparam int AMM_LUT_ADDR_W  = 18;
  localparam int AMM_LUT_DATA_W  = 8;
  localparam int LUT_CLEAN_WORDS = 2**AMM_LUT_ADDR_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOST = 2'd1,
    CLEAN     = 2'd2,
    DONE      = 2'd3
  } lut_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/bloom_lut_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bloom_lut_ctrl_if
// Brief    : Avalon-MM link used for both the host side and the LUT side.
// Revision : 1.0
// ============================================================================
interface bloom_lut_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, write, read, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, write, read, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/bloom_lut_sweep.sv
`default_nettype none
// ============================================================================
// Module   : bloom_lut_sweep
// Brief    : Clean sweep address counter with advance, clear and last-word flag.
// Revision : 1.0
// ============================================================================
module bloom_lut_sweep #(
  parameter int AMM_LUT_ADDR_W = 18,
  parameter int CLEAN_WORDS    = 2**AMM_LUT_ADDR_W
) (
  input  wire logic                      clk_i,
  input  wire logic                      srst_i,
  input  wire logic                      adv_i,
  input  wire logic                      clr_i,
  output logic [AMM_LUT_ADDR_W-1:0]      addr_o,
  output logic                           last_o
);

  localparam logic [AMM_LUT_ADDR_W-1:0] C_LAST = AMM_LUT_ADDR_W'(CLEAN_WORDS - 1);

  logic [AMM_LUT_ADDR_W-1:0] counter_q;
  logic [AMM_LUT_ADDR_W-1:0] counter_d;

  // Accepting the last word folds back to zero so the next sweep starts clean.
  always_comb begin
    counter_d = counter_q;
    if (clr_i) begin
      counter_d = '0;
    end else if (adv_i) begin
      counter_d = (counter_q == C_LAST) ? '0 : counter_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign addr_o = counter_q;
  assign last_o = (counter_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/bloom_lut_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bloom_lut_ctrl
// Brief    : Host/clean-engine arbiter for the bloom-filter hash LUT port.
//            Optional BLOOM_LUT_CLEAN_ON_RESET_EN: start a sweep out of reset.
// Revision : 1.0
// ============================================================================
module bloom_lut_ctrl #(
  parameter int AMM_LUT_ADDR_W = bloom_filter_pkg::AMM_LUT_ADDR_W,
  parameter int AMM_LUT_DATA_W = bloom_filter_pkg::AMM_LUT_DATA_W,
  parameter int CLEAN_WORDS    = 2**AMM_LUT_ADDR_W
) (
  input  wire logic          clk_i,
  input  wire logic          srst_i,
  input  wire logic          en_i,
  input  wire logic          clean_req_i,
  output logic               clean_busy_o,
  output logic               clean_done_o,
  output logic               filter_en_o,
  bloom_lut_ctrl_if.slave    host,
  bloom_lut_ctrl_if.master   lut
);

  import bloom_filter_pkg::*;

`ifdef BLOOM_LUT_CLEAN_ON_RESET_EN
  localparam lut_ctrl_state_t C_RESET_STATE = CLEAN;
`else
  localparam lut_ctrl_state_t C_RESET_STATE = IDLE;
`endif

  lut_ctrl_state_t           state_q;
  lut_ctrl_state_t           state_d;
  logic [AMM_LUT_ADDR_W-1:0] w_sweep_addr;
  logic                      w_sweep_last;
  logic                      w_sweep_adv;
  logic                      w_host_cmd;

  assign w_host_cmd  = host.write | host.read;
  assign w_sweep_adv = (state_q == CLEAN) && !lut.waitrequest;

  bloom_lut_sweep #(
    .AMM_LUT_ADDR_W (AMM_LUT_ADDR_W),
    .CLEAN_WORDS    (CLEAN_WORDS)
  ) u_sweep (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .adv_i  (w_sweep_adv),
    .clr_i  (state_q != CLEAN),
    .addr_o (w_sweep_addr),
    .last_o (w_sweep_last)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= C_RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // A stalled host command must finish before the port is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clean_req_i) begin
          state_d = (w_host_cmd && lut.waitrequest) ? WAIT_HOST : CLEAN;
        end
      end
      WAIT_HOST: begin
        if (!lut.waitrequest) begin
          state_d = CLEAN;
        end
      end
      CLEAN: begin
        if (w_sweep_adv && w_sweep_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lut.address      = host.address;
    lut.write        = host.write;
    lut.read         = host.read;
    lut.writedata    = host.writedata;
    host.waitrequest = lut.waitrequest;
    case (state_q)
      CLEAN: begin
        lut.address      = w_sweep_addr;
        lut.write        = 1'b1;
        lut.read         = 1'b0;
        lut.writedata    = '0;
        host.waitrequest = 1'b1;
      end
      DONE: begin
        lut.write        = 1'b0;
        lut.read         = 1'b0;
        host.waitrequest = 1'b1;
      end
      default: ;
    endcase
    // Reads issued before a clean still return while it runs.
    host.readdata      = lut.readdata;
    host.readdatavalid = lut.readdatavalid;
    clean_busy_o       = (state_q != IDLE);
    clean_done_o       = (state_q == DONE);
    filter_en_o        = en_i && (state_q == IDLE);
  end

endmodule
`default_nettype wire
